// File: rtl/fft_pkg.sv
// Shared FFT constants, index helpers and data types.
// Latency: n/a (package).
// Backpressure: n/a (package).
package fft_pkg;

    localparam int N    = 64;
    localparam int LOGN = 6;
    localparam int DW   = 16;
    localparam int AW   = LOGN - 1;

    // Last natural-order frequency index, N-1.
    localparam logic [LOGN-1:0] K_LAST = LOGN'(N - 1);

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    // One result beat as it travels through the unloader's output buffer.
    typedef struct packed {
        cplx_t           data;
        logic [LOGN-1:0] idx;
        logic            last;
    } unl_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } unl_state_t;

    // Reverse the 6 index bits: natural frequency k lives at stored index bitrev6(k).
    function automatic logic [5:0] bitrev6(input logic [5:0] v);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) begin
            r[i] = v[5 - i];
        end
        return r;
    endfunction

    // XOR parity of a 6-bit index; selects the bank holding that index.
    function automatic logic parity6(input logic [5:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry valid/ready buffer with a registered head; outputs come straight from flops.
// Latency: 1 clk from push to o_pop_vld when empty.
// Backpressure: caller must not push when full unless popping the same cycle; o_count exposes occupancy for credit logic.
module fft_skid_fifo #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push_vld,
    input  logic [W-1:0] i_push_dat,
    output logic         o_pop_vld,
    input  logic         i_pop_rdy,
    output logic [W-1:0] o_pop_dat,
    output logic [1:0]   o_count
);

    logic         r_hv;
    logic         r_tv;
    logic [W-1:0] r_hd;
    logic [W-1:0] r_td;
    logic         w_pop;

    assign w_pop     = r_hv & i_pop_rdy;
    assign o_pop_vld = r_hv;
    assign o_pop_dat = r_hd;
    // Tail is only ever occupied behind a valid head, so count = hv + tv.
    assign o_count   = {r_hv & r_tv, r_hv ^ r_tv};

    // Head refills from the tail first to keep order, then from the incoming beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hv <= 1'b0;
            r_tv <= 1'b0;
            r_hd <= '0;
            r_td <= '0;
        end else if (!r_hv || w_pop) begin
            if (r_tv) begin
                r_hd <= r_td;
                r_hv <= 1'b1;
                r_tv <= i_push_vld;
                if (i_push_vld) begin
                    r_td <= i_push_dat;
                end
            end else if (i_push_vld) begin
                r_hd <= i_push_dat;
                r_hv <= 1'b1;
            end else begin
                r_hv <= 1'b0;
            end
        end else if (i_push_vld) begin
            r_td <= i_push_dat;
            r_tv <= 1'b1;
        end
    end

endmodule

// File: rtl/fft_output_unloader.sv
// Reads the 64 FFT results out of the two parity banks in natural order onto a valid/ready stream.
// Latency: first o_out_valid 3 clk after the edge sampling i_start; 1 result/clk with o_out_ready high.
// Backpressure: reads issue only while buffered + in-flight beats (after this cycle's pop) stay below 2.
module fft_output_unloader
    import fft_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_re_b0,
    output logic [AW-1:0]     o_raddr_b0,
    input  logic [2*DW-1:0]   i_rdata_b0,
    output logic              o_re_b1,
    output logic [AW-1:0]     o_raddr_b1,
    input  logic [2*DW-1:0]   i_rdata_b1,
    output logic              o_busy,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [2*DW-1:0]   o_out_data,
    output logic [LOGN-1:0]   o_out_index,
    output logic              o_out_last,
    output logic              o_done
);

    unl_state_t      r_state;
    unl_state_t      w_state_nxt;
    logic [LOGN-1:0] r_cnt;
    logic            r_arm;
    logic            r_rvld;
    logic            r_rtag;
    logic [LOGN-1:0] r_ridx;
    logic            r_done;

    logic            w_issue;
    logic            w_pop;
    logic [1:0]      w_occ;
    logic [2:0]      w_used;
    logic [LOGN-1:0] w_srev;
    logic [AW-1:0]   w_addr;
    logic            w_bank;
    unl_beat_t       w_push_beat;
    unl_beat_t       w_head_beat;

    assign w_srev = bitrev6(r_cnt);
    assign w_addr = AW'(w_srev >> 1);
    // parity(k) == parity(bitrev6(k)), so the bank can come straight from the counter.
    assign w_bank = parity6(r_cnt);

    assign w_pop  = o_out_valid & i_out_ready;
    // Slots that will be claimed once this cycle's pop retires: buffered beats plus the
    // beat returning from the banks now. A read issued now lands in the buffer next cycle.
    assign w_used = 3'(w_occ) + 3'(r_rvld) - 3'(w_pop);

    // Next-state and read-issue decode.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                // r_arm holds off the first read for one cycle so the bank read ports
                // have been handed over (busy already high) before we drive them.
                w_issue = !r_arm && (w_used < 3'd2);
                if (w_issue && (r_cnt == K_LAST)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_head_beat.last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read counter: cleared on an accepted start, advances per issued read, parks at N-1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_arm <= 1'b0;
        end else begin
            r_arm <= (r_state == ST_IDLE) && i_start;
            if ((r_state == ST_IDLE) && i_start) begin
                r_cnt <= '0;
            end else if (w_issue && (r_cnt != K_LAST)) begin
                r_cnt <= r_cnt + LOGN'(1);
            end
        end
    end

    // Carry bank tag and index alongside the one-cycle bank read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rvld <= 1'b0;
            r_rtag <= 1'b0;
            r_ridx <= '0;
        end else begin
            r_rvld <= w_issue;
            r_rtag <= w_bank;
            r_ridx <= r_cnt;
        end
    end

    // Completion pulse the cycle after the final handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DRAIN) && w_pop && w_head_beat.last;
        end
    end

    assign o_re_b0    = w_issue & ~w_bank;
    assign o_re_b1    = w_issue & w_bank;
    assign o_raddr_b0 = o_re_b0 ? w_addr : '0;
    assign o_raddr_b1 = o_re_b1 ? w_addr : '0;

    assign w_push_beat.data = r_rtag ? i_rdata_b1 : i_rdata_b0;
    assign w_push_beat.idx  = r_ridx;
    assign w_push_beat.last = (r_ridx == K_LAST);

    fft_skid_fifo #(
        .W($bits(unl_beat_t))
    ) u_skid (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push_vld (r_rvld),
        .i_push_dat (w_push_beat),
        .o_pop_vld  (o_out_valid),
        .i_pop_rdy  (i_out_ready),
        .o_pop_dat  (w_head_beat),
        .o_count    (w_occ)
    );

    assign o_out_data  = w_head_beat.data;
    assign o_out_index = w_head_beat.idx;
    assign o_out_last  = w_head_beat.last;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;

endmodule

// File: tb/tb_fft_output_unloader.sv
// Directed bench for fft_output_unloader with a bit-reversal reference model and per-cycle monitor.
// Latency: n/a.
// Backpressure: out_ready is driven held-high, with a 5-clk drop at k=10, or random per cycle.
module tb_fft_output_unloader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic        re_b0, re_b1, busy, out_valid, out_last, done;
    logic [4:0]  raddr_b0, raddr_b1;
    logic [31:0] rdata_b0 = '0;
    logic [31:0] rdata_b1 = '0;
    logic [31:0] out_data;
    logic [5:0]  out_index;

    logic [31:0] bank0 [32];
    logic [31:0] bank1 [32];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic rst_q = 1'b0;

    int rdy_mode = 0;
    int bp_left  = 0;
    bit bp_done  = 1'b0;

    // monitor bookkeeping, owned by the monitor process
    int issued = 0, accepted = 0, exp_k = 0;
    int start_cyc = 0, first_vld_cyc = -1, first_hs_cyc = 0, last_hs_cyc = 0;
    bit pend_done = 1'b0, hold_prev = 1'b0;
    logic [31:0] hold_data;
    logic [6:0]  hold_meta;

    fft_output_unloader dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_re_b0     (re_b0),
        .o_raddr_b0  (raddr_b0),
        .i_rdata_b0  (rdata_b0),
        .o_re_b1     (re_b1),
        .o_raddr_b1  (raddr_b1),
        .i_rdata_b1  (rdata_b1),
        .o_busy      (busy),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_index (out_index),
        .o_out_last  (out_last),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ref_rev(input int k);
        int r = 0;
        for (int i = 0; i < 6; i++) r = r * 2 + ((k >> i) & 1);
        return r;
    endfunction

    function automatic int ref_bank(input int k);
        int s = ref_rev(k);
        int p = 0;
        for (int i = 0; i < 6; i++) p = p + ((s >> i) & 1);
        return p % 2;
    endfunction

    function automatic int ref_data(input int k);
        return 32 * ref_bank(k) + (ref_rev(k) / 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- bank memories ----------------
    initial begin
        for (int a = 0; a < 32; a++) begin
            bank0[a] = 32'(a);
            bank1[a] = 32'(32 + a);
        end
    end

    always @(posedge clk) begin
        if (re_b0) rdata_b0 <= bank0[raddr_b0];
        if (re_b1) rdata_b1 <= bank1[raddr_b1];
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // ---------------- out_ready driver ----------------
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) begin
            out_ready = 1'($urandom_range(0, 1));
        end else if (rdy_mode == 2) begin
            if (bp_left != 0) begin
                out_ready = 1'b0;
                bp_left--;
            end else if (!bp_done && out_valid && out_index == 6'd10) begin
                out_ready = 1'b0;
                bp_left   = 4;
                bp_done   = 1'b1;
            end else begin
                out_ready = 1'b1;
            end
        end else begin
            out_ready = 1'b1;
            bp_done   = 1'b0;
        end
    end

    // ---------------- monitor / compare ----------------
    always @(negedge clk) begin
        if (rst_q) begin
            chk("reset_ctrl", {10'd0, re_b0, re_b1, busy, out_valid, out_last, done,
                               raddr_b0, raddr_b1, out_index}, 32'd0);
            chk("reset_data", out_data, 32'd0);
            issued = 0; accepted = 0; exp_k = 0;
            first_vld_cyc = -1; pend_done = 1'b0; hold_prev = 1'b0;
        end else begin
            if (pend_done) begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 0);
                chk("done_re", {re_b0, re_b1}, 0);
            end else begin
                chk("done_quiet", done, 0);
            end
            pend_done = 1'b0;

            if (re_b0 || re_b1) begin
                chk("one_bank", re_b0 & re_b1, 0);
                chk("issue_count", issued < 64, 1);
                chk("issue_bank", re_b1, ref_bank(issued));
                chk("issue_addr", re_b1 ? raddr_b1 : raddr_b0, ref_rev(issued) / 2);
                case (issued)
                    0:  chk("pin_k0_addr",  {re_b0, raddr_b0}, 32'h20);
                    1:  chk("pin_k1_addr",  {re_b1, raddr_b1}, 32'h30);
                    3:  chk("pin_k3_addr",  {re_b0, raddr_b0}, 32'h38);
                    63: chk("pin_k63_addr", {re_b0, raddr_b0}, 32'h3f);
                    default: ;
                endcase
                issued++;
            end

            if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;

            if (hold_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_data);
                chk("hold_meta", {out_index, out_last}, hold_meta);
            end

            if (out_valid && out_ready) begin
                chk("out_index", out_index, exp_k);
                chk("out_data", out_data, ref_data(exp_k));
                chk("out_last", out_last, exp_k == 63);
                case (exp_k)
                    0:  chk("pin_k0_data", out_data, 32'd0);
                    1:  chk("pin_k1_data", out_data, 32'd48);
                    3:  chk("pin_k3_data", out_data, 32'd24);
                    63: chk("pin_k63_data", out_data, 32'd31);
                    default: ;
                endcase
                if (accepted == 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                accepted++;
                exp_k++;
                if (out_last) pend_done = 1'b1;
            end

            chk("outstanding", (issued - accepted) <= 2, 1);

            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
            hold_meta = {out_index, out_last};

            if (start && !busy) begin
                issued = 0; accepted = 0; exp_k = 0;
                first_vld_cyc = -1;
                start_cyc = cyc + 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) return;
        end
        checks++; errors++;
        $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", budget, cyc);
    endtask

    task automatic wait_index(input int k, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (out_valid && out_index == 6'(k)) return;
        end
        checks++; errors++;
        $display("FAIL index_timeout: index %0d not seen within %0d cycles", k, budget);
    endtask

    task automatic check_unload(input string tag, input bit full_rate);
        chk({tag, "_total"}, accepted, 64);
        chk({tag, "_issued"}, issued, 64);
        chk({tag, "_latency"}, first_vld_cyc - start_cyc, 3);
        if (full_rate) chk({tag, "_span"}, last_hs_cyc - first_hs_cyc, 63);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        // A: full rate, addressing and latency
        do_start();
        wait_done(400);
        check_unload("A", 1'b1);

        // B: backpressure at k=10 for 5 clk
        rdy_mode = 2;
        @(posedge clk); #1;
        do_start();
        wait_done(400);
        check_unload("B", 1'b0);
        chk("B_bp_applied", bp_done, 1);
        rdy_mode = 0;
        @(posedge clk); #1;

        // C: start pulsed mid-unload is ignored
        do_start();
        wait_index(20, 200);
        do_start();
        wait_done(400);
        check_unload("C", 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("C_stays_idle", {busy, out_valid}, 0);
        end

        // D: random ready, three back-to-back unloads
        rdy_mode = 1;
        @(posedge clk); #1;
        for (int u = 0; u < 3; u++) begin
            do_start();
            wait_done(1000);
            check_unload("D", 1'b0);
        end
        rdy_mode = 0;
        @(posedge clk); #1;

        // E: reset mid-stream, then restart from k=0
        do_start();
        wait_index(30, 200);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("E_rst_ctrl", {re_b0, re_b1, busy, out_valid, out_last, done}, 0);
        chk("E_rst_index", out_index, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_start();
        wait_done(400);
        check_unload("E", 1'b1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
